// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared register file types and address width constants
package ibex_pkg;

    localparam int unsigned RF_AW_RV32I = 5;
    localparam int unsigned RF_AW_RV32E = 4;

    typedef enum logic [1:0] {
        RF_CLR_IDLE,
        RF_CLR_CLEAR,
        RF_CLR_DONE
    } rf_clr_state_e;

endpackage

// File: rtl/ibex_rf_clear_fsm.sv
// rtl/ibex_rf_clear_fsm.sv - sequential clear engine walking registers 1..NumWords-1
module ibex_rf_clear_fsm
    import ibex_pkg::*;
#(
    parameter int unsigned NumWords = 32,
    parameter int unsigned AW       = $clog2(NumWords)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          busy_o,
    output logic          done_o
);

    rf_clr_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_CLR_IDLE: begin
                if (clr_req_i) begin
                    state_d = RF_CLR_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            RF_CLR_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NumWords - 1)) begin
                    state_d = RF_CLR_DONE;
                end
            end
            RF_CLR_DONE: state_d = RF_CLR_IDLE;
            default:     state_d = RF_CLR_IDLE;
        endcase
    end

    always_comb begin
        clr_we_o   = (state_q == RF_CLR_CLEAR);
        clr_addr_o = cnt_q;
        busy_o     = (state_q != RF_CLR_IDLE);
        done_o     = (state_q == RF_CLR_DONE);
    end

endmodule

// File: rtl/ibex_register_file_mp.sv
// rtl/ibex_register_file_mp.sv - multi-port flop register file with pending scoreboard and clear engine
// Define IBEX_RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module ibex_register_file_mp
    import ibex_pkg::*;
#(
    parameter int unsigned          NumWords     = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          NumReadPorts = 2,
    parameter logic [DataWidth-1:0] WordZeroVal  = '0,
    localparam int unsigned         AW           = $clog2(NumWords)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReadPorts*AW-1:0]     raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic                           we_a_i,
    input  logic [AW-1:0]                  waddr_a_i,
    input  logic [DataWidth-1:0]           wdata_a_i,
    input  logic                           we_b_i,
    input  logic [AW-1:0]                  waddr_b_i,
    input  logic [DataWidth-1:0]           wdata_b_i,
    input  logic                           pend_set_i,
    input  logic [AW-1:0]                  pend_addr_i,
    output logic [NumWords-1:0]            pend_o,
    input  logic                           clr_req_i,
    output logic                           clr_busy_o,
    output logic                           clr_done_o,
    output logic                           err_o
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          port_en;
    logic          err_q;
    logic [DataWidth-1:0] rf_rd [NumWords];

    ibex_rf_clear_fsm #(
        .NumWords (NumWords),
        .AW       (AW)
    ) u_clear_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_req_i  (clr_req_i),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (clr_busy_o),
        .done_o     (clr_done_o)
    );

    // All external updates are frozen while the clear engine owns the array.
    assign port_en = !clr_busy_o;

    assign rf_rd[0]  = WordZeroVal;
    assign pend_o[0] = 1'b0;

    for (genvar r = 1; r < NumWords; r++) begin : g_reg
        logic                 clr_hit, a_hit, b_hit, p_hit;
        logic [DataWidth-1:0] data_q;
        logic                 pend_q;

        assign clr_hit = clr_we && (clr_addr == AW'(r));
        assign a_hit   = port_en && we_a_i && (waddr_a_i == AW'(r));
        assign b_hit   = port_en && we_b_i && (waddr_b_i == AW'(r));
        assign p_hit   = port_en && pend_set_i && (pend_addr_i == AW'(r));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= WordZeroVal;
                pend_q <= 1'b0;
            end else begin
                if (clr_hit)    data_q <= WordZeroVal;
                else if (a_hit) data_q <= wdata_a_i;
                else if (b_hit) data_q <= wdata_b_i;

                if (clr_hit)    pend_q <= 1'b0;
                else if (p_hit) pend_q <= 1'b1;
                else if (b_hit) pend_q <= 1'b0;
            end
        end

        assign rf_rd[r]  = data_q;
        assign pend_o[r] = pend_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= port_en && we_a_i && we_b_i && (waddr_a_i == waddr_b_i) &&
                     (waddr_a_i != '0);
        end
    end
    assign err_o = err_q;

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [AW-1:0]        ra;
        logic [DataWidth-1:0] rd;

        assign ra = raddr_i[p*AW +: AW];
`ifdef IBEX_RF_BYPASS_EN
        always_comb begin
            rd = rf_rd[ra];
            if (port_en && we_b_i && (waddr_b_i == ra) && (ra != '0)) rd = wdata_b_i;
            if (port_en && we_a_i && (waddr_a_i == ra) && (ra != '0)) rd = wdata_a_i;
        end
`else
        assign rd = rf_rd[ra];
`endif
        assign rdata_o[p*DataWidth +: DataWidth] = rd;
    end

endmodule
